// File: rtl/main_memory_responder_pkg.sv
// Shared memory-interface definitions for the L1 data cache, its controller and the
// main-memory responder.
package main_memory_responder_pkg;

    localparam int unsigned CACHE_BLOCK_SIZE  = 128;
    localparam int unsigned BLOCK_OFFSET_BITS = $clog2(CACHE_BLOCK_SIZE / 8);

    typedef logic [CACHE_BLOCK_SIZE-1:0] mem_block_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRespond
    } mem_resp_state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO holding pending block-read indices; pushes when full and pops when
// empty are ignored.
module mem_req_fifo #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory endpoint: queues block reads and answers each after a fixed latency,
// while committing evicted-block writebacks to an uncleared backing store.
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_BLOCKS = 1024,
    parameter int unsigned RESP_LATENCY     = 8,
    parameter int unsigned REQ_QUEUE_DEPTH  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        mem_req_vld_i,
    input  logic [31:0]                 mem_req_addr_i,
    output logic                        mem_req_rdy_o,
    output logic                        mem_resp_vld_o,
    output logic [CACHE_BLOCK_SIZE-1:0] mem_resp_data_o,
    input  logic                        mem_wb_vld_i,
    input  logic [31:0]                 mem_wb_addr_i,
    input  logic [CACHE_BLOCK_SIZE-1:0] mem_wb_data_i,
    output logic                        busy_o,
    output logic                        req_overflow_o
);

    localparam int unsigned IdxW     = $clog2(MEM_DEPTH_BLOCKS);
    localparam int unsigned CntW     = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
    localparam int unsigned FifoCntW = $clog2(REQ_QUEUE_DEPTH) + 1;

    mem_block_t      store_q [MEM_DEPTH_BLOCKS];
    mem_block_t      rd_data;
    mem_block_t      resp_data_q;
    mem_resp_state_t state_q;
    logic [CntW-1:0] cnt_q;
    logic [IdxW-1:0] req_idx, wb_idx, head_idx, cur_idx_q;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic [FifoCntW-1:0] fifo_count;
    logic            overflow_q;
    logic            unused_addr_bits;

    // Offset bits and address bits above the store index alias onto the same block.
    assign req_idx          = mem_req_addr_i[BLOCK_OFFSET_BITS +: IdxW];
    assign wb_idx           = mem_wb_addr_i[BLOCK_OFFSET_BITS +: IdxW];
    assign unused_addr_bits = ^{mem_req_addr_i, mem_wb_addr_i};

    assign fifo_pop = (state_q == StIdle) && !fifo_empty;

    mem_req_fifo #(
        .Width (IdxW),
        .Depth (REQ_QUEUE_DEPTH)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (mem_req_vld_i),
        .data_i  (req_idx),
        .pop_i   (fifo_pop),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (mem_wb_vld_i) begin
            store_q[wb_idx] <= mem_wb_data_i;
        end
    end

    // Read in RESPOND is combinational, so a same-cycle writeback is seen only afterwards.
    assign rd_data = store_q[cur_idx_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cur_idx_q   <= '0;
            resp_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (mem_req_vld_i && fifo_full) begin
                overflow_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        cur_idx_q <= head_idx;
                        cnt_q     <= CntW'(RESP_LATENCY - 1);
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StRespond;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StRespond: begin
                    resp_data_q <= rd_data;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_resp_vld_o  = (state_q == StRespond);
    assign mem_resp_data_o = mem_resp_vld_o ? rd_data : resp_data_q;
    assign mem_req_rdy_o   = !fifo_full;
    assign busy_o          = (fifo_count != '0) || (state_q != StIdle);
    assign req_overflow_o  = overflow_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: expected blocks are queued at request time
// and a negedge monitor compares every response pulse against the queue head.
module tb_main_memory_responder;
    import main_memory_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_req_vld_i;
    logic [31:0] mem_req_addr_i;
    logic        mem_req_rdy_o;
    logic        mem_resp_vld_o;
    mem_block_t  mem_resp_data_o;
    logic        mem_wb_vld_i;
    logic [31:0] mem_wb_addr_i;
    mem_block_t  mem_wb_data_i;
    logic        busy_o;
    logic        req_overflow_o;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    mem_block_t exp_q[$];
    int         resp_cyc_q[$];
    mem_block_t mon_exp;

    localparam mem_block_t DataA5 = {16{8'hA5}};
    localparam mem_block_t Data11 = {32{4'h1}};
    localparam mem_block_t Data22 = {32{4'h2}};
    localparam mem_block_t Data44 = {32{4'h4}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    main_memory_responder #(
        .MEM_DEPTH_BLOCKS (1024),
        .RESP_LATENCY     (8),
        .REQ_QUEUE_DEPTH  (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .mem_req_vld_i   (mem_req_vld_i),
        .mem_req_addr_i  (mem_req_addr_i),
        .mem_req_rdy_o   (mem_req_rdy_o),
        .mem_resp_vld_o  (mem_resp_vld_o),
        .mem_resp_data_o (mem_resp_data_o),
        .mem_wb_vld_i    (mem_wb_vld_i),
        .mem_wb_addr_i   (mem_wb_addr_i),
        .mem_wb_data_i   (mem_wb_data_i),
        .busy_o          (busy_o),
        .req_overflow_o  (req_overflow_o)
    );

    task automatic check_val(input string name, input mem_block_t act, input mem_block_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_resp_vld_o === 1'b1) begin
            resp_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got data %h at cycle %0d expected none",
                         mem_resp_data_o, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("resp_data", mem_resp_data_o, mon_exp);
            end
        end
    end

    task automatic do_wb(input logic [31:0] a, input mem_block_t d);
        mem_wb_vld_i  = 1'b1;
        mem_wb_addr_i = a;
        mem_wb_data_i = d;
        @(negedge clk);
        mem_wb_vld_i = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] a, input mem_block_t d, output int acc);
        check_val("req_rdy", mem_block_t'(mem_req_rdy_o), mem_block_t'(1));
        mem_req_vld_i  = 1'b1;
        mem_req_addr_i = a;
        exp_q.push_back(d);
        @(negedge clk);
        mem_req_vld_i = 1'b0;
        acc = cyc;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_resp_vld"}, mem_block_t'(mem_resp_vld_o), '0);
        check_val({tag, "_resp_data"}, mem_resp_data_o, '0);
        check_val({tag, "_rdy"}, mem_block_t'(mem_req_rdy_o), mem_block_t'(1));
        check_val({tag, "_busy"}, mem_block_t'(busy_o), '0);
        check_val({tag, "_overflow"}, mem_block_t'(req_overflow_o), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int t0;
        rst_i          = 1'b1;
        mem_req_vld_i  = 1'b0;
        mem_req_addr_i = '0;
        mem_wb_vld_i   = 1'b0;
        mem_wb_addr_i  = '0;
        mem_wb_data_i  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        @(negedge clk);

        // Basic latency: accept at edge T, response in cycle T+9, idle afterwards.
        do_wb(32'h50, DataA5);
        do_req(32'h50, DataA5, t);
        repeat (8) @(negedge clk);
        check_val("lat_not_early", mem_block_t'(mem_resp_vld_o), '0);
        @(negedge clk);
        check_val("lat_vld", mem_block_t'(mem_resp_vld_o), mem_block_t'(1));
        @(negedge clk);
        check_val("pulse_single", mem_block_t'(mem_resp_vld_o), '0);
        check_val("busy_after", mem_block_t'(busy_o), '0);

        // Writeback then read two cycles later.
        do_wb(32'h30, Data11);
        @(negedge clk);
        do_req(32'h30, Data11, t);
        drain(30);

        // Writeback during WAIT is visible.
        do_req(32'h40, Data22, t);
        repeat (3) @(negedge clk);
        do_wb(32'h40, Data22);
        drain(30);

        // Writeback in the RESPOND cycle: old data now, new data on the next read.
        do_req(32'h40, Data22, t);
        repeat (9) @(negedge clk);
        check_val("respond_cycle", mem_block_t'(mem_resp_vld_o), mem_block_t'(1));
        do_wb(32'h40, Data44);
        drain(30);
        do_req(32'h40, Data44, t);
        drain(30);

        // Overflow: six back-to-back requests, only five fit (one in service + four queued).
        for (int i = 0; i < 5; i++) begin
            do_wb(32'h60 + 32'(i * 16), {16{8'(8'h61 + i)}});
        end
        check_val("overflow_clear", mem_block_t'(req_overflow_o), '0);
        resp_cyc_q.delete();
        t0 = 0;
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("burst_rdy%0d", i), mem_block_t'(mem_req_rdy_o),
                      (i < 5) ? mem_block_t'(1) : mem_block_t'(0));
            mem_req_vld_i  = 1'b1;
            mem_req_addr_i = 32'h60 + 32'(i * 16);
            if (i < 5) begin
                exp_q.push_back({16{8'(8'h61 + i)}});
            end
            @(negedge clk);
            if (i == 0) begin
                t0 = cyc;
            end
        end
        mem_req_vld_i = 1'b0;
        check_val("overflow_set", mem_block_t'(req_overflow_o), mem_block_t'(1));
        drain(80);
        repeat (12) @(negedge clk);
        check_int("burst_resp_count", resp_cyc_q.size(), 5);
        if (resp_cyc_q.size() == 5) begin
            check_int("burst_first_lat", resp_cyc_q[0], t0 + 9);
            for (int i = 1; i < 5; i++) begin
                check_int($sformatf("burst_spacing%0d", i), resp_cyc_q[i] - resp_cyc_q[i-1], 10);
            end
        end

        // Reset during WAIT abandons the response; the store keeps its contents.
        resp_cyc_q.delete();
        mem_req_vld_i  = 1'b1;
        mem_req_addr_i = 32'h50;
        @(negedge clk);
        mem_req_vld_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_reset_outputs("midreset");
        repeat (15) @(negedge clk);
        check_int("no_resp_after_reset", resp_cyc_q.size(), 0);
        do_req(32'h30, Data11, t);
        drain(30);

        // Address aliasing on offset and upper bits.
        do_req(32'h50, DataA5, t);
        drain(30);
        do_req(32'h50 + 32'(1024 * 16), DataA5, t);
        drain(30);
        do_req(32'h8000_005C, DataA5, t);
        drain(30);

        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
